// File: rtl/uart_tx_dev.sv
// Bridge-mapped UART transmitter: CPU-filled byte FIFO, 8N1 serialiser, drain interrupt.
// Define UART_TX_PARITY_EN to add an optional parity bit (CTRL[2] par_en, CTRL[3] par_odd).
module uart_tx_dev #(
   parameter int FIFO_DEPTH  = 8,
   parameter int DIV_W       = 16,
   parameter int DIV_DEFAULT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  ADD_I,
   input  logic        WE_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        IRQ,
   output logic        txd
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t           state_reg, state_next;
   logic [DIV_W-1:0] timer_reg, timer_next;
   logic [7:0]       shift_reg, shift_next;
   logic [2:0]       bit_reg, bit_next;
   logic             txd_reg, txd_next;
   logic             irq_reg;
   logic             tx_en_reg, irq_en_reg, ovf_reg;
   logic [DIV_W-1:0] baud_reg;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [3:0]       count_sat;

   logic fifo_empty, fifo_full, data_we, ctrl_we, status_we, baud_we;
   logic push, pop, can_start, bit_done;
   logic [7:0]       head;
   logic [DIV_W-1:0] baud_wr_val;

`ifdef UART_TX_PARITY_EN
   logic par_reg, par_next, par_en_reg, par_odd_reg;
`endif

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
   assign data_we    = WE_I && (ADD_I == 2'd0);
   assign ctrl_we    = WE_I && (ADD_I == 2'd1);
   assign status_we  = WE_I && (ADD_I == 2'd2);
   assign baud_we    = WE_I && (ADD_I == 2'd3);
   // A write into a full FIFO still lands when the same edge frees a slot.
   assign push       = data_we && (!fifo_full || pop);
   assign head       = mem[rd_ptr_reg];
   assign can_start  = tx_en_reg && !fifo_empty;
   assign bit_done   = (timer_reg <= DIV_W'(1));
   assign count_sat  = (32'(count_reg) > 32'd15) ? 4'hF : 4'(count_reg);
   assign baud_wr_val = (DAT_I[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : DAT_I[DIV_W-1:0];
   assign txd        = txd_reg;
   assign IRQ        = irq_reg;

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      shift_next = shift_reg;
      bit_next   = bit_reg;
      txd_next   = txd_reg;
      pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_next   = par_reg;
`endif
      case (state_reg)
         IDLE: begin
            txd_next = 1'b1;
            if (can_start) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            timer_next = timer_reg - DIV_W'(1);
            if (bit_done) begin
               state_next = DATA;
               timer_next = baud_reg;
               bit_next   = 3'd0;
               txd_next   = shift_reg[0];
            end
         end
         DATA: begin
            timer_next = timer_reg - DIV_W'(1);
            if (bit_done) begin
               timer_next = baud_reg;
               if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  if (par_en_reg) begin
                     state_next = PARITY;
                     txd_next   = par_reg ^ par_odd_reg;
                  end else begin
                     state_next = STOP;
                     txd_next   = 1'b1;
                  end
`else
                  state_next = STOP;
                  txd_next   = 1'b1;
`endif
               end else begin
                  bit_next   = bit_reg + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  txd_next   = shift_reg[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            timer_next = timer_reg - DIV_W'(1);
            if (bit_done) begin
               state_next = STOP;
               timer_next = baud_reg;
               txd_next   = 1'b1;
            end
         end
`endif
         STOP: begin
            timer_next = timer_reg - DIV_W'(1);
            if (bit_done) begin
               if (can_start) begin
                  pop        = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      // Loading the head byte is shared by the idle start and the back-to-back start.
      if (pop) begin
         shift_next = head;
         timer_next = baud_reg;
         txd_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_next   = ^head;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         timer_reg  <= '0;
         shift_reg  <= '0;
         bit_reg    <= '0;
         txd_reg    <= 1'b1;
         irq_reg    <= 1'b0;
         tx_en_reg  <= 1'b0;
         irq_en_reg <= 1'b0;
         ovf_reg    <= 1'b0;
         baud_reg   <= DIV_W'(DIV_DEFAULT);
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         shift_reg <= shift_next;
         bit_reg   <= bit_next;
         txd_reg   <= txd_next;
         irq_reg   <= irq_en_reg && fifo_empty && (state_reg == IDLE);
         if (ctrl_we) begin
            tx_en_reg  <= DAT_I[0];
            irq_en_reg <= DAT_I[1];
         end
         if (baud_we)
            baud_reg <= baud_wr_val;
         if (data_we && fifo_full && !pop)
            ovf_reg <= 1'b1;
         else if (status_we)
            ovf_reg <= 1'b0;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (push && !pop)
            count_reg <= count_reg + CW'(1);
         else if (pop && !push)
            count_reg <= count_reg - CW'(1);
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_reg     <= 1'b0;
         par_en_reg  <= 1'b0;
         par_odd_reg <= 1'b0;
      end else begin
         par_reg <= par_next;
         if (ctrl_we) begin
            par_en_reg  <= DAT_I[2];
            par_odd_reg <= DAT_I[3];
         end
      end
   end
`endif

   // Storage needs no reset: pointer reset discards the contents.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= DAT_I[7:0];
   end

   always_comb begin
      DAT_O = 32'd0;
      case (ADD_I)
`ifdef UART_TX_PARITY_EN
         2'd1: DAT_O = {28'd0, par_odd_reg, par_en_reg, irq_en_reg, tx_en_reg};
`else
         2'd1: DAT_O = {30'd0, irq_en_reg, tx_en_reg};
`endif
         2'd2: DAT_O = {24'd0, count_sat, ovf_reg, fifo_empty, fifo_full, state_reg != IDLE};
         2'd3: DAT_O = 32'(baud_reg);
         default: DAT_O = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: register table, directed frame scenarios,
// and randomized byte bursts decoded from txd and compared with a byte-queue model.
module tb_uart_tx_dev;

   localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
   localparam logic [31:0] CTRL_ALL = 32'hF;
`else
   localparam logic [31:0] CTRL_ALL = 32'h3;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ADD_I;
   logic        WE_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic        IRQ;
   logic        txd;

   int total = 0;
   int bad   = 0;
   logic [7:0] model_q[$];

   always #5 clk = ~clk;

   uart_tx_dev #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DIV_DEFAULT(434)) dut (
      .clk(clk), .reset(reset), .ADD_I(ADD_I), .WE_I(WE_I),
      .DAT_I(DAT_I), .DAT_O(DAT_O), .IRQ(IRQ), .txd(txd)
   );

   typedef struct {
      bit          wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
      ADD_I = addr;
      DAT_I = data;
      WE_I  = 1'b1;
      tick();
      WE_I  = 1'b0;
      ADD_I = 2'd2;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
      ADD_I = addr;
      #1;
      data  = DAT_O;
      ADD_I = 2'd2;
      #1;
   endtask

   function automatic logic [31:0] status_exp(input int cnt, input bit busy, input bit ovf);
      int c;
      c = (cnt > 15) ? 15 : cnt;
      return (32'(c) << 4) | (32'(ovf) << 3) | (32'(cnt == 0) << 2)
           | (32'(cnt == DEPTH) << 1) | 32'(busy);
   endfunction

   task automatic wait_low(input int budget, output int waited);
      waited = 0;
      while (txd !== 1'b0 && waited < budget) begin
         tick();
         waited++;
      end
      check("frame_start_seen", 32'(txd), 32'd0);
   endtask

   // Decode one frame starting at its first start-bit cycle. Each bit must hold
   // for exactly div cycles; busy must be 1 and IRQ 0 throughout (ADD_I=STATUS).
   task automatic recv_frame(input int div, input int nbits,
                             output logic [7:0] data, output logic par, output int errs);
      logic [10:0] bits;
      bits = '0;
      errs = 0;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < div; c++) begin
            if (c == 0) bits[b] = txd;
            else if (txd !== bits[b]) errs++;
            if (DAT_O[0] !== 1'b1 || IRQ !== 1'b0) errs++;
            tick();
         end
      end
      if (bits[0] !== 1'b0) errs++;
      if (bits[nbits-1] !== 1'b1) errs++;
      data = bits[8:1];
      par  = bits[9];
   endtask

   task automatic drain(input int div);
      logic [7:0]  d;
      logic [7:0]  exp_b;
      logic        p;
      int          e;
      logic [31:0] st;
      while (model_q.size() > 0) begin
         exp_b = model_q.pop_front();
         recv_frame(div, 10, d, p, e);
         $display("frame rx=%02h want=%02h div=%0d", d, exp_b, div);
         check("frame_data", 32'(d), 32'(exp_b));
         check("frame_shape", 32'(e), 32'd0);
         if (model_q.size() > 0) check("back_to_back", 32'(txd), 32'd0);
      end
      bus_read(2'd2, st);
      check("status_after_drain", st, status_exp(0, 0, 0));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[10];
      logic [31:0] rd;
      int          waited, n, div, run1, run2;
      logic [7:0]  b;
      logic        rec[24];

      vecs[0] = '{1'b1, 2'd1, 32'hFFFF_FFFF, CTRL_ALL,     "ctrl_all"};
      vecs[1] = '{1'b1, 2'd1, 32'h0,         32'h0,        "ctrl_zero"};
      vecs[2] = '{1'b1, 2'd3, 32'h0,         32'h2,        "baud_0_clamped"};
      vecs[3] = '{1'b1, 2'd3, 32'h1,         32'h2,        "baud_1_clamped"};
      vecs[4] = '{1'b1, 2'd3, 32'h2,         32'h2,        "baud_2"};
      vecs[5] = '{1'b1, 2'd3, 32'h0001_0007, 32'h7,        "baud_width"};
      vecs[6] = '{1'b1, 2'd3, 32'h0000_FFFF, 32'hFFFF,     "baud_max"};
      vecs[7] = '{1'b0, 2'd0, 32'h0,         32'h0,        "data_reads_0"};
      vecs[8] = '{1'b1, 2'd2, 32'hFF,        32'h4,        "status_readonly"};
      vecs[9] = '{1'b1, 2'd3, 32'h4,         32'h4,        "baud_4"};

      reset = 1'b0;
      ADD_I = 2'd2;
      WE_I  = 1'b0;
      DAT_I = 32'd0;
      repeat (3) tick();
      check("reset_txd_async", 32'(txd), 32'd1);
      reset = 1'b1;
      tick();

      check("reset_txd", 32'(txd), 32'd1);
      check("reset_irq", 32'(IRQ), 32'd0);
      bus_read(2'd2, rd); check("reset_status", rd, status_exp(0, 0, 0));
      bus_read(2'd1, rd); check("reset_ctrl", rd, 32'd0);
      bus_read(2'd3, rd); check("reset_baud", rd, 32'd434);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
         bus_read(vecs[i].addr, rd);
         check(vecs[i].name, rd, vecs[i].exp);
      end

      // Single byte 0x55 at BAUD=4: low one cycle after the write edge, 40-cycle frame.
      bus_write(2'd1, 32'h1);
      bus_write(2'd0, 32'h55); model_q.push_back(8'h55);
      wait_low(10, waited);
      check("start_latency", 32'(waited), 32'd1);
      drain(4);

      // Two queued bytes released together run back to back.
      bus_write(2'd1, 32'h0);
      bus_write(2'd0, 32'hA5); model_q.push_back(8'hA5);
      bus_write(2'd0, 32'h3C); model_q.push_back(8'h3C);
      bus_read(2'd2, rd); check("status_two_queued", rd, status_exp(2, 0, 0));
      bus_write(2'd1, 32'h1);
      wait_low(10, waited);
      check("start_latency_2", 32'(waited), 32'd1);
      drain(4);

      // Nine writes into eight slots, overflow clear, then a write on the pop edge.
      bus_write(2'd1, 32'h0);
      for (int i = 0; i < 9; i++) begin
         b = 8'(8'h10 + i);
         bus_write(2'd0, 32'(b));
         if (i < DEPTH) model_q.push_back(b);
      end
      bus_read(2'd2, rd); check("status_overflow", rd, status_exp(8, 0, 1));
      bus_write(2'd2, 32'h0);
      bus_read(2'd2, rd); check("status_ovf_cleared", rd, status_exp(8, 0, 0));
      bus_write(2'd1, 32'h1);
      bus_write(2'd0, 32'h5A); model_q.push_back(8'h5A);
      bus_read(2'd2, rd); check("status_push_on_pop", rd, status_exp(8, 1, 0));
      wait_low(10, waited);
      drain(4);

      // Interrupt: low while busy, high one cycle after the stop bit, cleared by a write.
      bus_write(2'd1, 32'h3);
      bus_write(2'd0, 32'h96); model_q.push_back(8'h96);
      wait_low(10, waited);
      drain(4);
      check("irq_low_at_stop_end", 32'(IRQ), 32'd0);
      tick();
      check("irq_raised", 32'(IRQ), 32'd1);
      bus_write(2'd0, 32'hC3); model_q.push_back(8'hC3);
      tick();
      check("irq_cleared_by_write", 32'(IRQ), 32'd0);
      wait_low(10, waited);
      drain(4);
      bus_write(2'd1, 32'h1);

      // BAUD 4->8 written mid bit 2 of 0x55 (bits 2,3 = 1,0).
      bus_write(2'd0, 32'h55);
      wait_low(10, waited);
      repeat (12) tick();
      for (int i = 0; i < 24; i++) begin
         rec[i] = txd;
         if (i == 1) bus_write(2'd3, 32'h8);
         else tick();
      end
      run1 = 0;
      while (run1 < 24 && rec[run1] === 1'b1) run1++;
      run2 = 0;
      while (run1 + run2 < 24 && rec[run1+run2] === 1'b0) run2++;
      check("bit2_len", 32'(run1), 32'd4);
      check("bit3_len", 32'(run2), 32'd8);

      // tx_en dropped and a byte queued, then reset mid-frame.
      bus_write(2'd1, 32'h0);
      bus_write(2'd0, 32'h11);
      check("pre_reset_midframe_low", 32'(txd), 32'd0);
      reset = 1'b0;
      #1;
      check("reset_mid_txd", 32'(txd), 32'd1);
      bus_read(2'd2, rd); check("reset_mid_status", rd, status_exp(0, 0, 0));
      reset = 1'b1;
      tick();
      bus_read(2'd3, rd); check("reset_mid_baud", rd, 32'd434);
      model_q.delete();

      // Randomized bursts against the byte-queue model.
      for (int r = 0; r < 4; r++) begin
         div = $urandom_range(2, 6);
         n   = $urandom_range(1, DEPTH);
         bus_write(2'd1, 32'h0);
         bus_write(2'd3, 32'(div));
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_write(2'd0, 32'(b));
            model_q.push_back(b);
         end
         bus_read(2'd2, rd); check("rand_status", rd, status_exp(n, 0, 0));
         bus_write(2'd1, 32'h1);
         wait_low(10, waited);
         check("rand_start_latency", 32'(waited), 32'd1);
         drain(div);
      end

`ifdef UART_TX_PARITY_EN
      begin
         logic [7:0] d;
         logic       p;
         int         e;
         bus_write(2'd3, 32'h4);
         bus_write(2'd1, 32'h5);
         bus_write(2'd0, 32'h07);
         wait_low(10, waited);
         recv_frame(4, 11, d, p, e);
         check("par_data", 32'(d), 32'h07);
         check("par_bit", 32'(p), 32'd1);
         check("par_shape", 32'(e), 32'd0);
         bus_read(2'd2, rd); check("par_44_cycles", rd, status_exp(0, 0, 0));
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
